// File: rtl/exp_frac_unit_pkg.sv
// Shared constants, fixed-point types and the series helper for the e^f datapath.
// Formats: input 0.18, LUT 2.18, polynomial 1.24, product 3.42, output 4.18.
package exp_frac_unit_pkg;

  localparam int FRAC_BITS = 18;
  localparam int OUT_WIDTH = 22;
  localparam int LUT_BITS  = 6;
  localparam int B_W       = FRAC_BITS - LUT_BITS;
  localparam int L_W       = 20;
  localparam int P_W       = 25;
  localparam int P_FRAC    = P_W - 1;
  localparam int Q_W       = L_W + P_W;
  localparam int SQ_W      = 2 * B_W;
  localparam int B_ALIGN   = P_FRAC - FRAC_BITS;
  localparam int SQ_SHIFT  = 2 * FRAC_BITS + 1 - P_FRAC;

  localparam logic [P_W-1:0] P_ONE  = P_W'(1) << P_FRAC;
  localparam logic [Q_W-1:0] Q_HALF = Q_W'(1) << (P_FRAC - 1);

  typedef logic [FRAC_BITS-1:0] frac_t;
  typedef logic [OUT_WIDTH-1:0] exp_t;
  typedef logic [L_W-1:0]       lut_t;
  typedef logic [P_W-1:0]       poly_t;
  typedef logic [Q_W-1:0]       prod_t;

  typedef struct packed {
    logic [LUT_BITS-1:0] a;
    logic [B_W-1:0]      b;
  } frac_split_t;

  // 1 + b + b^2/2 in 1.24; the halved square is truncated to 2^-24.
  function automatic poly_t exp_poly(input logic [B_W-1:0] b);
    logic [SQ_W-1:0] b_sq;
    b_sq = SQ_W'(b) * SQ_W'(b);
    return P_ONE + (P_W'(b) << B_ALIGN) + P_W'(b_sq >> SQ_SHIFT);
  endfunction

endpackage

// File: rtl/exp_frac_unit_lut.sv
// 64x20 ROM of round(e^(k/64) * 2^18) with a registered, resettable read port.
// One cycle read latency; no backpressure.
module exp_frac_unit_lut
  import exp_frac_unit_pkg::*;
(
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [LUT_BITS-1:0] addr,
  output logic [L_W-1:0]      data
);

  lut_t rom_val;

  always_comb begin
    rom_val = '0;
    case (addr)
      6'd0:  rom_val = 20'd262144;  6'd1:  rom_val = 20'd266272;
      6'd2:  rom_val = 20'd270465;  6'd3:  rom_val = 20'd274725;
      6'd4:  rom_val = 20'd279051;  6'd5:  rom_val = 20'd283445;
      6'd6:  rom_val = 20'd287909;  6'd7:  rom_val = 20'd292443;
      6'd8:  rom_val = 20'd297048;  6'd9:  rom_val = 20'd301726;
      6'd10: rom_val = 20'd306477;  6'd11: rom_val = 20'd311304;
      6'd12: rom_val = 20'd316206;  6'd13: rom_val = 20'd321186;
      6'd14: rom_val = 20'd326243;  6'd15: rom_val = 20'd331381;
      6'd16: rom_val = 20'd336600;  6'd17: rom_val = 20'd341900;
      6'd18: rom_val = 20'd347284;  6'd19: rom_val = 20'd352753;
      6'd20: rom_val = 20'd358308;  6'd21: rom_val = 20'd363951;
      6'd22: rom_val = 20'd369682;  6'd23: rom_val = 20'd375504;
      6'd24: rom_val = 20'd381417;  6'd25: rom_val = 20'd387424;
      6'd26: rom_val = 20'd393525;  6'd27: rom_val = 20'd399722;
      6'd28: rom_val = 20'd406017;  6'd29: rom_val = 20'd412410;
      6'd30: rom_val = 20'd418905;  6'd31: rom_val = 20'd425502;
      6'd32: rom_val = 20'd432202;  6'd33: rom_val = 20'd439009;
      6'd34: rom_val = 20'd445922;  6'd35: rom_val = 20'd452944;
      6'd36: rom_val = 20'd460077;  6'd37: rom_val = 20'd467322;
      6'd38: rom_val = 20'd474681;  6'd39: rom_val = 20'd482157;
      6'd40: rom_val = 20'd489749;  6'd41: rom_val = 20'd497462;
      6'd42: rom_val = 20'd505296;  6'd43: rom_val = 20'd513253;
      6'd44: rom_val = 20'd521336;  6'd45: rom_val = 20'd529545;
      6'd46: rom_val = 20'd537885;  6'd47: rom_val = 20'd546355;
      6'd48: rom_val = 20'd554959;  6'd49: rom_val = 20'd563698;
      6'd50: rom_val = 20'd572575;  6'd51: rom_val = 20'd581592;
      6'd52: rom_val = 20'd590751;  6'd53: rom_val = 20'd600054;
      6'd54: rom_val = 20'd609503;  6'd55: rom_val = 20'd619101;
      6'd56: rom_val = 20'd628851;  6'd57: rom_val = 20'd638754;
      6'd58: rom_val = 20'd648813;  6'd59: rom_val = 20'd659030;
      6'd60: rom_val = 20'd669408;  6'd61: rom_val = 20'd679950;
      6'd62: rom_val = 20'd690657;  6'd63: rom_val = 20'd701534;
      default: rom_val = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) data <= '0;
    else        data <= rom_val;
  end

endmodule

// File: rtl/exp_frac_unit.sv
// e^f for an 18-bit pure fraction: e^a from a ROM times the series 1+b+b^2/2, rounded to 4.18.
// Latency 2 cycles; accepts a new input every cycle, no backpressure.
module exp_frac_unit
  import exp_frac_unit_pkg::*;
(
  input  logic                 CLK,
  input  logic                 iRstN,
  input  logic [FRAC_BITS-1:0] iX,
  output logic [OUT_WIDTH-1:0] oExp
);

  frac_split_t x_split;
  lut_t        lut_q;
  poly_t       poly_q;
  prod_t       prod;
  exp_t        exp_nxt;

  assign x_split = iX;

  exp_frac_unit_lut u_lut (
    .CLK   (CLK),
    .rst_n (iRstN),
    .addr  (x_split.a),
    .data  (lut_q)
  );

  // Stage 1: polynomial registered alongside the ROM read.
  always_ff @(posedge CLK) begin
    if (!iRstN) poly_q <= '0;
    else        poly_q <= exp_poly(x_split.b);
  end

  // Stage 2: 3.42 product, round-half-up into 4.18. A cleared stage 1 yields 0 here.
  always_comb begin
    prod    = prod_t'(lut_q) * prod_t'(poly_q);
    exp_nxt = exp_t'((prod + Q_HALF) >> P_FRAC);
  end

  always_ff @(posedge CLK) begin
    if (!iRstN) oExp <= '0;
    else        oExp <= exp_nxt;
  end

endmodule

// File: tb/tb_exp_frac_unit.sv
// Directed bench for exp_frac_unit: reset, exact points, streaming latency, mid-stream reset, sweep.
module tb_exp_frac_unit;

  logic        CLK;
  logic        iRstN;
  logic [17:0] iX;
  logic [21:0] oExp;

  int checks;
  int errors;

  exp_frac_unit dut (
    .CLK   (CLK),
    .iRstN (iRstN),
    .iX    (iX),
    .oExp  (oExp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic check_tol(input string tag, input logic [21:0] obs, input real want, input real tol);
    real diff;
    checks++;
    diff = real'(obs) - want;
    assert (!$isunknown(obs) && diff <= tol && diff >= -tol) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0f +/-%0f", tag, obs, want, tol);
    end
  endtask

  initial begin
    logic [21:0] prev;
    logic [17:0] x;
    real         model;
    checks = 0;
    errors = 0;

    // Reset held for 3 edges with e^0.5 on the input.
    iRstN = 1'b0;
    iX    = 18'h20000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rst_hold_%0d", i), oExp, 22'd0);
    end
    iRstN = 1'b1;
    tick();
    check_eq("rst_release_e1", oExp, 22'd0);
    tick();
    check_eq("rst_release_half", oExp, 22'd432202);

    // Exact and boundary points, one at a time.
    iX = 18'h00000; tick(); tick();
    check_eq("x_zero", oExp, 22'd262144);
    iX = 18'h01000; tick(); tick();
    check_eq("x_a1_b0", oExp, 22'd266272);
    iX = 18'h10000; tick(); tick();
    check_eq("x_quarter", oExp, 22'd336600);
    iX = 18'h3FFFF; tick(); tick();
    check_tol("x_max", oExp, 712579.0, 2.0);
    check_eq("x_max_headroom", {20'd0, oExp[21:20]}, 22'd0);
    iX = 18'h00FFF; tick(); tick();
    check_tol("x_b_max_a0", oExp, 266271.0, 2.0);
    iX = 18'h08800; tick(); tick();
    check_tol("x_a8_bmid", oExp, 299378.0, 2.0);

    // Streaming: four inputs on consecutive cycles, results on four consecutive cycles.
    iX = 18'h00000; tick();
    iX = 18'h01000; tick();
    check_eq("stream_0", oExp, 22'd262144);
    iX = 18'h20000; tick();
    check_eq("stream_1", oExp, 22'd266272);
    iX = 18'h3FFFF; tick();
    check_eq("stream_2", oExp, 22'd432202);
    iX = 18'h00000; tick();
    check_tol("stream_3", oExp, 712579.0, 2.0);

    // One-cycle reset while two samples are in flight.
    iX = 18'h3FFFF; tick();
    iX = 18'h20000; iRstN = 1'b0; tick();
    check_eq("midrst_out0", oExp, 22'd0);
    iX = 18'h10000; iRstN = 1'b1; tick();
    check_eq("midrst_out1", oExp, 22'd0);
    iX = 18'h00000; tick();
    check_eq("midrst_first", oExp, 22'd336600);
    tick();
    check_eq("midrst_second", oExp, 22'd262144);

    // Sweep: 514 increasing points ending at 0x3FFFF, against e^f and for monotonicity.
    prev = '0;
    for (int i = 0; i < 514; i++) begin
      x  = 18'(i * 511);
      iX = x;
      tick(); tick();
      model = $exp(real'(x) / 262144.0) * 262144.0;
      check_tol($sformatf("sweep_%05h", x), oExp, model, 2.0);
      checks++;
      assert (oExp >= prev && oExp[21:20] == 2'b00) else begin
        errors++;
        $error("FAIL sweep_mono_%05h: observed %0d expected >= %0d with top bits 0", x, oExp, prev);
      end
      prev = oExp;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
